// File: rtl/mem_pkg.sv
// Shared definitions for the Memory-stage port controller: opcodes,
// controller states, byte-lane geometry and grant encoding.
package mem_pkg;

  // Memory-stage operation codes carried on dm_op
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;

  // Byte-lane geometry: lane 0 is bits [7:0], lane 3 is bits [31:24]
  localparam int LANE_W     = 8;
  localparam int NUM_LANES  = 4;
  localparam int LANE_SEL_W = 2;

  // Last-grant encoding for the round-robin arbiter
  localparam logic GRANT_DATA  = 1'b0;
  localparam logic GRANT_FETCH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR
  } state_t;

  // True for the four opcodes that touch memory
  function automatic logic op_is_valid(input logic [6:0] op);
    return (op == OP_LDB) || (op == OP_LDW) || (op == OP_STB) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: extracts a zero-extended byte from a word and merges a
// byte into a word. One instance serves both the LDB and STB paths.
module mem_byte_lane
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]     word,
  input  logic [LANE_SEL_W-1:0] lane,
  input  logic [LANE_W-1:0]     byte_in,
  output logic [DATA_W-1:0]     byte_out,
  output logic [DATA_W-1:0]     merged
);

  logic [LANE_W-1:0] lanes [NUM_LANES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lanes[gi] = word[gi*LANE_W +: LANE_W];
      assign merged[gi*LANE_W +: LANE_W] =
        (lane == LANE_SEL_W'(gi)) ? byte_in : word[gi*LANE_W +: LANE_W];
    end
    // Any bits above the four byte lanes pass straight through a merge
    if (DATA_W > NUM_LANES*LANE_W) begin : g_upper
      assign merged[DATA_W-1:NUM_LANES*LANE_W] = word[DATA_W-1:NUM_LANES*LANE_W];
    end
  endgenerate

  assign byte_out = {{(DATA_W-LANE_W){1'b0}}, lanes[lane]};

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbitration and sequencing for the single-ported data memory shared by
// instruction fetch and the Memory-stage data port. Byte stores are done
// as a read-modify-write; byte loads extract one lane of the read word.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // data requester
  input  logic              dm_req,
  input  logic [6:0]        dm_op,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [4:0]        dm_dst,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic              wb,
  output logic [4:0]        wb_dst,
  output logic [DATA_W-1:0] wb_data,
  // memory handshake
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int WA_W = ADDR_W - 2;

  state_t state_reg, state_next;

  // Latched request context and round-robin history
  logic                  last_grant_reg, last_grant_next;
  logic                  owner_reg, owner_next;
  logic [6:0]            op_reg, op_next;
  logic [LANE_SEL_W-1:0] lane_reg, lane_next;
  logic [LANE_W-1:0]     byte_reg, byte_next;
  logic [4:0]            dst_reg, dst_next;

  // Registered outputs
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [WA_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              if_done_reg, if_done_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic              dm_done_reg, dm_done_next;
  logic              wb_reg, wb_next;
  logic [4:0]        wb_dst_reg, wb_dst_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;

  // Arbitration results
  logic dm_elig, if_elig, accept, pick_fetch;

  // Byte-lane helper results
  logic [DATA_W-1:0] lane_byte, lane_merged;

  // Word alignment bits of the fetch address are don't-care
  logic unused_if_bits;
  assign unused_if_bits = ^if_addr[1:0];

  mem_byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
    .word     (mem_rdata),
    .lane     (lane_reg),
    .byte_in  (byte_reg),
    .byte_out (lane_byte),
    .merged   (lane_merged)
  );

  // Round-robin pick; a requester in its done cycle sits out this round
  always_comb begin
    dm_elig    = dm_req && !dm_done_reg;
    if_elig    = if_req && !if_done_reg;
    accept     = dm_elig || if_elig;
    pick_fetch = if_elig && (!dm_elig || (last_grant_reg == GRANT_DATA));
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (pick_fetch) begin
            state_next = ST_RD;
          end else begin
            case (dm_op)
              OP_LDB, OP_LDW: state_next = ST_RD;
              OP_STW:         state_next = ST_WR;
              OP_STB:         state_next = ST_RMW_RD;
              default:        state_next = ST_IDLE;
            endcase
          end
        end
      end
      ST_RD, ST_WR: if (mem_ack) state_next = ST_IDLE;
      ST_RMW_RD:    if (mem_ack) state_next = ST_RMW_WR;
      ST_RMW_WR:    if (mem_ack) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Next values for the request context and all registered outputs
  always_comb begin
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    op_next         = op_reg;
    lane_next       = lane_reg;
    byte_next       = byte_reg;
    dst_next        = dst_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    if_done_next    = 1'b0;
    if_rdata_next   = '0;
    dm_done_next    = 1'b0;
    wb_next         = 1'b0;
    wb_dst_next     = '0;
    wb_data_next    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (pick_fetch) begin
            last_grant_next = GRANT_FETCH;
            owner_next      = GRANT_FETCH;
            op_next         = OP_LDW;
            lane_next       = '0;
            mem_req_next    = 1'b1;
            mem_we_next     = 1'b0;
            mem_addr_next   = if_addr[ADDR_W-1:2];
          end else begin
            last_grant_next = GRANT_DATA;
            owner_next      = GRANT_DATA;
            op_next         = dm_op;
            lane_next       = dm_addr[1:0];
            byte_next       = dm_wdata[LANE_W-1:0];
            dst_next        = dm_dst;
            if (op_is_valid(dm_op)) begin
              mem_req_next   = 1'b1;
              mem_we_next    = (dm_op == OP_STW);
              mem_addr_next  = dm_addr[ADDR_W-1:2];
              mem_wdata_next = dm_wdata;
            end else begin
              // Unknown op: acknowledge without touching memory
              dm_done_next = 1'b1;
            end
          end
        end
      end

      ST_RD: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (owner_reg == GRANT_FETCH) begin
            if_done_next  = 1'b1;
            if_rdata_next = mem_rdata;
          end else begin
            dm_done_next = 1'b1;
            wb_next      = 1'b1;
            wb_dst_next  = dst_reg;
            wb_data_next = (op_reg == OP_LDB) ? lane_byte : mem_rdata;
          end
        end
      end

      ST_WR, ST_RMW_WR: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          dm_done_next = 1'b1;
        end
      end

      ST_RMW_RD: begin
        // Keep the request up and turn it into the write of the merged word
        if (mem_ack) begin
          mem_we_next    = 1'b1;
          mem_wdata_next = lane_merged;
        end
      end

      default: ;
    endcase
  end

  // Context and output registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= GRANT_FETCH;
      owner_reg      <= GRANT_DATA;
      op_reg         <= '0;
      lane_reg       <= '0;
      byte_reg       <= '0;
      dst_reg        <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      if_done_reg    <= 1'b0;
      if_rdata_reg   <= '0;
      dm_done_reg    <= 1'b0;
      wb_reg         <= 1'b0;
      wb_dst_reg     <= '0;
      wb_data_reg    <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      op_reg         <= op_next;
      lane_reg       <= lane_next;
      byte_reg       <= byte_next;
      dst_reg        <= dst_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      if_done_reg    <= if_done_next;
      if_rdata_reg   <= if_rdata_next;
      dm_done_reg    <= dm_done_next;
      wb_reg         <= wb_next;
      wb_dst_reg     <= wb_dst_next;
      wb_data_reg    <= wb_data_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_done   = if_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_done   = dm_done_reg;
  assign wb        = wb_reg;
  assign wb_dst    = wb_dst_reg;
  assign wb_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: transaction-level reference model of the
// memory and the arbiter, a memory responder, directed scenarios with
// literal expectations, then randomized traffic from both requesters.
module tb_mem_port_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int NWORDS = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic [6:0]        dm_op = '0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [4:0]        dm_dst = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_done;
  logic              wb;
  logic [4:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;

  mem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_op(dm_op), .dm_addr(dm_addr), .dm_dst(dm_dst),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .wb(wb), .wb_dst(wb_dst),
    .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int lane, input logic [7:0] b);
    logic [31:0] mask;
    mask = 32'hFF << (8*lane);
    return (w & ~mask) | ({24'h0, b} << (8*lane));
  endfunction

  function automatic logic [31:0] get_byte(input logic [31:0] w, input int lane);
    return (w >> (8*lane)) & 32'hFF;
  endfunction

  // Physical memory seen by the DUT, and the model's view of it
  logic [31:0] phys_mem [NWORDS];
  logic [31:0] ref_mem  [NWORDS];

  // 0 = random ack, 1 = always ack, 2 = never ack
  int ack_mode = 1;

  // Memory responder: acks (also randomly while idle, which must be ignored)
  always @(negedge clk) begin
    logic a;
    case (ack_mode)
      1:       a = 1'b1;
      2:       a = 1'b0;
      default: a = ($urandom_range(0, 1) == 1);
    endcase
    mem_ack   = a;
    mem_rdata = phys_mem[mem_addr];
    if (mem_req && a && mem_we) phys_mem[mem_addr] = mem_wdata;
  end

  // Inputs as the DUT sees them at the rising edge
  logic              a_if_req, a_dm_req, a_ack;
  logic [ADDR_W-1:0] a_if_addr, a_dm_addr;
  logic [6:0]        a_dm_op;
  logic [4:0]        a_dm_dst;
  logic [DATA_W-1:0] a_dm_wdata;

  always @(posedge clk) begin
    a_if_req   = if_req;
    a_if_addr  = if_addr;
    a_dm_req   = dm_req;
    a_dm_op    = dm_op;
    a_dm_addr  = dm_addr;
    a_dm_dst   = dm_dst;
    a_dm_wdata = dm_wdata;
    a_ack      = mem_ack;
  end

  // Reference model state: one transaction in service at a time
  logic              m_busy = 1'b0, m_fetch = 1'b0, m_phase = 1'b0, last_fetch = 1'b1;
  logic [6:0]        m_op = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [4:0]        m_dst = '0;
  logic [31:0]       m_wdata = '0, m_merged = '0;
  logic              e_if_done = 1'b0, e_dm_done = 1'b0, e_wb = 1'b0, e_we = 1'b0;
  logic [4:0]        e_wb_dst = '0;
  logic [31:0]       e_if_rdata = '0, e_wb_data = '0, e_wdata = '0;

  // Advance the model over the edge just passed, then compare every output
  always @(negedge clk) begin
    logic n_if_done, n_dm_done, n_wb, ed, ef, pf;
    logic [4:0] n_dst;
    logic [31:0] n_wbd, n_ifd;
    logic [7:0] wa;
    if (reset) begin
      m_busy = 1'b0; m_phase = 1'b0; last_fetch = 1'b1;
      e_if_done = 1'b0; e_dm_done = 1'b0; e_wb = 1'b0; e_we = 1'b0;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_done", 32'(if_done), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_done", 32'(dm_done), 0);
      chk("rst_wb", 32'(wb), 0);
      chk("rst_wb_dst", 32'(wb_dst), 0);
      chk("rst_wb_data", wb_data, 0);
    end else begin
      n_if_done = 1'b0; n_dm_done = 1'b0; n_wb = 1'b0; n_dst = '0; n_wbd = '0; n_ifd = '0;
      wa = m_addr[9:2];
      if (m_busy) begin
        if (a_ack) begin
          if (!m_fetch && m_op == OP_STB && !m_phase) begin
            m_merged = put_byte(ref_mem[wa], int'(m_addr[1:0]), m_wdata[7:0]);
            m_phase = 1'b1; e_we = 1'b1; e_wdata = m_merged;
          end else begin
            m_busy = 1'b0; e_we = 1'b0;
            if (m_fetch) begin
              n_if_done = 1'b1; n_ifd = ref_mem[wa];
            end else begin
              n_dm_done = 1'b1;
              if (m_op == OP_LDW) begin
                n_wb = 1'b1; n_dst = m_dst; n_wbd = ref_mem[wa];
              end else if (m_op == OP_LDB) begin
                n_wb = 1'b1; n_dst = m_dst; n_wbd = get_byte(ref_mem[wa], int'(m_addr[1:0]));
              end else if (m_op == OP_STW) begin
                ref_mem[wa] = m_wdata;
              end else begin
                ref_mem[wa] = m_merged;
              end
            end
          end
        end
      end else begin
        ed = a_dm_req && !e_dm_done;
        ef = a_if_req && !e_if_done;
        if (ed || ef) begin
          pf = ef && (!ed || !last_fetch);
          last_fetch = pf; m_fetch = pf; m_phase = 1'b0;
          if (pf) begin
            m_addr = a_if_addr; m_busy = 1'b1; e_we = 1'b0;
          end else begin
            m_op = a_dm_op; m_addr = a_dm_addr; m_dst = a_dm_dst; m_wdata = a_dm_wdata;
            if (a_dm_op inside {OP_LDB, OP_LDW, OP_STB, OP_STW}) begin
              m_busy = 1'b1; e_we = (a_dm_op == OP_STW); e_wdata = a_dm_wdata;
            end else begin
              n_dm_done = 1'b1;
            end
          end
        end
      end
      e_if_done = n_if_done; e_if_rdata = n_ifd;
      e_dm_done = n_dm_done; e_wb = n_wb; e_wb_dst = n_dst; e_wb_data = n_wbd;

      chk("mem_req", 32'(mem_req), 32'(m_busy));
      if (m_busy) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr[9:2]));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("if_done", 32'(if_done), 32'(e_if_done));
      chk("dm_done", 32'(dm_done), 32'(e_dm_done));
      if (e_if_done) chk("if_rdata", if_rdata, e_if_rdata);
      if (e_dm_done) begin
        chk("wb", 32'(wb), 32'(e_wb));
        chk("wb_dst", 32'(wb_dst), 32'(e_wb_dst));
        chk("wb_data", wb_data, e_wb_data);
      end
    end
  end

  // One data transaction from an idle negedge; reports latency and WB
  task automatic do_dm(input logic [6:0] op, input logic [9:0] addr, input logic [4:0] dst,
                       input logic [31:0] wd, output int lat, output int reqc,
                       output logic w, output logic [4:0] d, output logic [31:0] data);
    lat = 0; reqc = 0; w = 1'b0; d = '0; data = '0;
    @(negedge clk);
    dm_op = op; dm_addr = addr; dm_dst = dst; dm_wdata = wd; dm_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (mem_req) reqc++;
      if (dm_done) begin
        w = wb; d = wb_dst; data = wb_data;
        break;
      end
    end
    chk("dm_timeout", 32'(dm_done), 1);
    $display("txn op=%h addr=%h lat=%0d wb=%0d dst=%0d data=%h", op, addr, lat, w, d, data);
    dm_req = 1'b0;
  endtask

  task automatic new_dm();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    dm_op = OP_LDB;
      2, 3:    dm_op = OP_LDW;
      4, 5:    dm_op = OP_STB;
      6, 7:    dm_op = OP_STW;
      8:       dm_op = 7'h05;
      default: dm_op = 7'($urandom_range(0, 15));
    endcase
    dm_addr  = 10'($urandom_range(0, 63));
    dm_dst   = 5'($urandom_range(0, 31));
    dm_wdata = $urandom;
    dm_req   = 1'b1;
  endtask

  task automatic new_if();
    if_addr = 10'($urandom_range(0, 63));
    if_req  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, reqc, n;
    logic w;
    logic [4:0] d;
    logic [31:0] data;
    int order [6];

    for (int i = 0; i < NWORDS; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Contention straight after reset: data first, then strict alternation
    @(negedge clk);
    ack_mode = 1;
    dm_op = OP_LDW; dm_addr = 10'h024; dm_dst = 5'd3; if_addr = 10'h100;
    dm_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 6; k++) order[k] = 2;
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (dm_done && n < 6) begin order[n] = 0; n++; end
      if (if_done && n < 6) begin order[n] = 1; n++; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      $display("grant %0d -> %s", k, order[k] == 0 ? "D" : (order[k] == 1 ? "F" : "-"));
      chk("grant_order", order[k], (k % 2 == 0) ? 0 : 1);
    end

    // STW then LDW, single-cycle ack
    do_dm(OP_STW, 10'h024, 5'd0, 32'hDEADBEEF, lat, reqc, w, d, data);
    chk("stw_lat", lat, 2);
    chk("stw_wb", 32'(w), 0);
    do_dm(OP_LDW, 10'h024, 5'd5, 32'h0, lat, reqc, w, d, data);
    chk("ldw_lat", lat, 2);
    chk("ldw_wb", 32'(w), 1);
    chk("ldw_dst", 32'(d), 5);
    chk("ldw_data", data, 32'hDEADBEEF);

    // Byte store merge through read-modify-write
    do_dm(OP_STW, 10'h024, 5'd0, 32'h11223344, lat, reqc, w, d, data);
    do_dm(OP_STB, 10'h026, 5'd9, 32'h000000AB, lat, reqc, w, d, data);
    chk("stb_lat", lat, 3);
    chk("stb_req_cycles", reqc, 2);
    chk("stb_wb", 32'(w), 0);
    chk("stb_wb_data", data, 0);
    do_dm(OP_LDW, 10'h024, 5'd7, 32'h0, lat, reqc, w, d, data);
    chk("stb_merged", data, 32'h11AB3344);

    // Byte loads from two lanes
    do_dm(OP_STW, 10'h024, 5'd0, 32'h11223344, lat, reqc, w, d, data);
    do_dm(OP_LDB, 10'h027, 5'd1, 32'h0, lat, reqc, w, d, data);
    chk("ldb_lane3", data, 32'h00000011);
    do_dm(OP_LDB, 10'h024, 5'd2, 32'h0, lat, reqc, w, d, data);
    chk("ldb_lane0", data, 32'h00000044);
    chk("ldb_dst", 32'(d), 2);

    // Invalid op: no memory access, done right after acceptance
    do_dm(7'h05, 10'h030, 5'd4, 32'h0, lat, reqc, w, d, data);
    chk("inv_lat", lat, 1);
    chk("inv_wb", 32'(w), 0);
    chk("inv_req_cycles", reqc, 0);

    // Reset in the read half of a byte store
    ack_mode = 2;
    @(negedge clk);
    dm_op = OP_STB; dm_addr = 10'h024; dm_dst = 5'd0; dm_wdata = 32'h55; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_pending_req", 32'(mem_req), 1);
    #2 reset = 1'b1; dm_req = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 0);
    chk("rst_async_done", 32'(dm_done), 0);
    $display("reset mid-rmw: mem_req=%0d dm_done=%0d", mem_req, dm_done);
    @(negedge clk);
    #2 reset = 1'b0; ack_mode = 1;
    do_dm(OP_LDW, 10'h024, 5'd6, 32'h0, lat, reqc, w, d, data);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", data, 32'h11223344);

    // Randomized traffic from both requesters with random ack timing
    ack_mode = 0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (dm_req) begin
            if (dm_done) begin
              if ($urandom_range(0, 1) == 1) new_dm();
              else dm_req = 1'b0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            new_dm();
          end
        end
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (if_req) begin
            if (if_done) begin
              if ($urandom_range(0, 1) == 1) new_if();
              else if_req = 1'b0;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            new_if();
          end
        end
      end
    join
    // Let any in-flight transaction finish before dropping requests
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dm_done) dm_req = 1'b0;
      if (if_done) if_req = 1'b0;
      if (!mem_req && !dm_req && !if_req) break;
    end
    dm_req = 1'b0; if_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
